// File: rtl/ins_boot_loader.sv
// ins_boot_loader
// ---------------
// Streams a program image from a valid/ready word source into instruction
// memory. It then releases the core, times the core's run, and reports the
// run length in clock cycles.
//
// Ports
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   load_start_in         one-cycle load request (honoured in IDLE/DONE only)
//   base_pc_in            first instruction address, sampled with the request
//   word_count_in         number of words to load, sampled with the request
//   word_valid_in/ready   word stream handshake, data on word_data_in
//   ins_wr_*_out          one-word-per-cycle instruction memory write port
//   initial_pc_out        latched base address for the core
//   core_run_out          core release/enable
//   end_signal_in         core completion level
//   busy_out              high while LOAD, SETTLE or RUN
//   done_out              one-cycle pulse when the run completes
//   error_out             sticky flag for a rejected load request
//   run_cycles_out        cycles spent in RUN (saturating)
//   dbg_state_out         current FSM state encoding
//
// Handshake: a word moves on every rising edge where word_valid_in and
// word_ready_out are both high. word_ready_out depends only on the state
// (high throughout LOAD), never on word_valid_in. The source may present
// or withdraw a word on any cycle.

module ins_boot_loader #(
    parameter int MAX_WORDS     = 256,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_start_in,
    input  logic [31:0]      base_pc_in,
    input  logic [15:0]      word_count_in,
    input  logic             word_valid_in,
    input  logic [31:0]      word_data_in,
    output logic             word_ready_out,
    output logic             ins_wr_en_out,
    output logic [31:0]      ins_wr_addr_out,
    output logic [31:0]      ins_wr_data_out,
    output logic [31:0]      initial_pc_out,
    output logic             core_run_out,
    input  logic             end_signal_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             error_out,
    output logic [CNT_W-1:0] run_cycles_out,
    output logic [2:0]       dbg_state_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [15:0] MAX_W16 = MAX_WORDS[15:0];
    localparam int          SW      = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SETTLE_CYCLES[SW-1:0];

    state_t            r_state;
    state_t            w_next_state;

    logic [31:0]       r_base;
    logic [15:0]       r_count;
    logic [15:0]       r_index;
    logic [SW-1:0]     r_settle_cnt;
    logic [CNT_W-1:0]  r_run_cycles;
    logic              r_end_seen_low;
    logic              r_wr_en;
    logic [31:0]       r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_core_run;
    logic              r_done;
    logic              r_error;

    logic              w_start_req;
    logic              w_count_bad;
    logic              w_start_ok;
    logic              w_xfer;
    logic              w_last_word;
    logic              w_settle_done;
    logic              w_complete;

    // Requests are only looked at while the loader is not busy.
    assign w_start_req   = load_start_in && (r_state == S_IDLE || r_state == S_DONE);
    assign w_count_bad   = (word_count_in == 16'd0) || (word_count_in > MAX_W16);
    assign w_start_ok    = w_start_req && !w_count_bad;
    assign w_xfer        = (r_state == S_LOAD) && word_valid_in;
    assign w_last_word   = w_xfer && (r_index == r_count - 16'd1);
    // The first SETTLE cycle carries the final write strobe. SETTLE therefore
    // lasts SETTLE_CYCLES more cycles after that one.
    assign w_settle_done = (r_state == S_SETTLE) && (r_settle_cnt == SETTLE_LAST);
    // Only a rising edge counts as completion. The level must first be seen
    // low during RUN.
    assign w_complete    = (r_state == S_RUN) && end_signal_in && r_end_seen_low;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (w_start_ok)    w_next_state = S_LOAD;
            S_LOAD:         if (w_last_word)   w_next_state = S_SETTLE;
            S_SETTLE:       if (w_settle_done) w_next_state = S_RUN;
            S_RUN:          if (w_complete)    w_next_state = S_DONE;
            default:                           w_next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        word_ready_out = 1'b0;
        busy_out       = 1'b0;
        dbg_state_out  = r_state;
        case (r_state)
            S_LOAD: begin
                word_ready_out = 1'b1;
                busy_out       = 1'b1;
            end
            S_SETTLE, S_RUN: busy_out = 1'b1;
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_base         <= 32'd0;
            r_count        <= 16'd0;
            r_index        <= 16'd0;
            r_settle_cnt   <= '0;
            r_run_cycles   <= '0;
            r_end_seen_low <= 1'b0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= 32'd0;
            r_wr_data      <= 32'd0;
            r_core_run     <= 1'b0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_wr_en <= w_xfer;
            r_done  <= w_complete;

            if (w_start_ok) begin
                r_base         <= base_pc_in;
                r_count        <= word_count_in;
                r_index        <= 16'd0;
                r_error        <= 1'b0;
                r_run_cycles   <= '0;
                r_end_seen_low <= 1'b0;
            end else if (w_start_req) begin
                r_error <= 1'b1;
            end

            if (w_xfer) begin
                // The address wraps modulo 2^32 by construction.
                r_wr_addr <= r_base + {16'd0, r_index};
                r_wr_data <= word_data_in;
                r_index   <= r_index + 16'd1;
            end

            if (r_state == S_SETTLE && !w_settle_done) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end else begin
                r_settle_cnt <= '0;
            end

            if (w_settle_done) begin
                r_core_run <= 1'b1;
            end else if (w_complete) begin
                r_core_run <= 1'b0;
            end

            if (r_state == S_RUN) begin
                if (r_run_cycles != {CNT_W{1'b1}}) begin
                    r_run_cycles <= r_run_cycles + 1'b1;
                end
                if (!end_signal_in) begin
                    r_end_seen_low <= 1'b1;
                end
            end
        end
    end

    assign ins_wr_en_out   = r_wr_en;
    assign ins_wr_addr_out = r_wr_addr;
    assign ins_wr_data_out = r_wr_data;
    assign initial_pc_out  = r_base;
    assign core_run_out    = r_core_run;
    assign done_out        = r_done;
    assign error_out       = r_error;
    assign run_cycles_out  = r_run_cycles;

endmodule

// File: tb/tb_ins_boot_loader.sv
// Self-checking bench for ins_boot_loader. It keeps a transaction-level model
// of the loader, checks every output against it on each falling edge, and adds
// literal checks for the directed scenarios.

module tb_ins_boot_loader;

    localparam int MAX_WORDS     = 256;
    localparam int SETTLE_CYCLES = 2;
    localparam int CNT_W         = 32;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset_n = 1'b1;
    always #5 clock = ~clock;

    logic             load_start_in = 1'b0;
    logic [31:0]      base_pc_in = 32'd0;
    logic [15:0]      word_count_in = 16'd0;
    logic             word_valid_in = 1'b0;
    logic [31:0]      word_data_in = 32'd0;
    logic             end_signal_in = 1'b0;
    logic             word_ready_out;
    logic             ins_wr_en_out;
    logic [31:0]      ins_wr_addr_out;
    logic [31:0]      ins_wr_data_out;
    logic [31:0]      initial_pc_out;
    logic             core_run_out;
    logic             busy_out;
    logic             done_out;
    logic             error_out;
    logic [CNT_W-1:0] run_cycles_out;
    logic [2:0]       dbg_state_out;

    ins_boot_loader #(
        .MAX_WORDS    (MAX_WORDS),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .load_start_in  (load_start_in),
        .base_pc_in     (base_pc_in),
        .word_count_in  (word_count_in),
        .word_valid_in  (word_valid_in),
        .word_data_in   (word_data_in),
        .word_ready_out (word_ready_out),
        .ins_wr_en_out  (ins_wr_en_out),
        .ins_wr_addr_out(ins_wr_addr_out),
        .ins_wr_data_out(ins_wr_data_out),
        .initial_pc_out (initial_pc_out),
        .core_run_out   (core_run_out),
        .end_signal_in  (end_signal_in),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .error_out      (error_out),
        .run_cycles_out (run_cycles_out),
        .dbg_state_out  (dbg_state_out)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // The model tracks one program load as a list of pending words and
    // schedules the core release as an absolute edge number. The run is a
    // count of edges until a genuine low-to-high of the end level.
    int          cyc = 0;
    bit          m_loading = 0, m_pending = 0, m_running = 0, m_seen_low = 0;
    int          m_left = 0;
    int          m_release_edge = 0;
    logic [31:0] m_next_addr = 0;

    logic        e_wr_en = 0, e_core_run = 0, e_done = 0, e_error = 0;
    logic [31:0] e_addr = 0, e_data = 0, e_pc = 0, e_run = 0;

    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            m_loading = 0; m_pending = 0; m_running = 0; m_seen_low = 0;
            m_left = 0; m_next_addr = 0;
            e_wr_en = 0; e_core_run = 0; e_done = 0; e_error = 0;
            e_addr = 0; e_data = 0; e_pc = 0; e_run = 0;
        end else begin
            cyc++;
            e_wr_en = 0;
            e_done  = 0;
            if (!m_loading && !m_pending && !m_running) begin
                if (load_start_in) begin
                    if (word_count_in == 0 || int'(word_count_in) > MAX_WORDS) begin
                        e_error = 1;
                    end else begin
                        e_error = 0; e_pc = base_pc_in; e_run = 0;
                        m_left = int'(word_count_in); m_next_addr = base_pc_in;
                        m_seen_low = 0; m_loading = 1;
                    end
                end
            end else if (m_loading) begin
                if (word_valid_in) begin
                    e_wr_en = 1; e_addr = m_next_addr; e_data = word_data_in;
                    m_next_addr = m_next_addr + 32'd1;
                    m_left--;
                    if (m_left == 0) begin
                        m_loading = 0; m_pending = 1;
                        m_release_edge = cyc + 1 + SETTLE_CYCLES;
                    end
                end
            end else if (m_pending) begin
                if (cyc == m_release_edge) begin
                    m_pending = 0; m_running = 1; e_core_run = 1;
                end
            end else begin
                if (e_run != 32'hFFFF_FFFF) e_run = e_run + 32'd1;
                if (end_signal_in && m_seen_low) begin
                    m_running = 0; e_core_run = 0; e_done = 1;
                end else if (!end_signal_in) begin
                    m_seen_low = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clock);
        chk("word_ready", word_ready_out, 32'(m_loading));
        chk("busy",       busy_out, 32'(m_loading | m_pending | m_running));
        chk("wr_en",      ins_wr_en_out, e_wr_en);
        chk("wr_addr",    ins_wr_addr_out, e_addr);
        chk("wr_data",    ins_wr_data_out, e_data);
        chk("init_pc",    initial_pc_out, e_pc);
        chk("core_run",   core_run_out, e_core_run);
        chk("done",       done_out, e_done);
        chk("error",      error_out, e_error);
        chk("run_cycles", run_cycles_out, e_run);
    end

    // ---------------- strobe / done monitor ----------------
    logic [31:0] st_addr_q[$];
    int last_strobe_cyc = 0;
    int first_strobe_cyc = 0;
    int done_cnt = 0;
    initial forever begin
        @(negedge clock);
        if (reset_n && ins_wr_en_out) begin
            if (st_addr_q.size() == 0) first_strobe_cyc = cyc;
            st_addr_q.push_back(ins_wr_addr_out);
            last_strobe_cyc = cyc;
        end
        if (reset_n && done_out) done_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic start(input logic [31:0] base, input logic [15:0] cnt);
        @(negedge clock);
        load_start_in = 1; base_pc_in = base; word_count_in = cnt;
        @(negedge clock);
        load_start_in = 0;
    endtask

    // Drives n words starting at data d0. pat gives the valid pattern
    // (LSB first, plen bits); plen==0 means continuous valid.
    task automatic send(input int n, input logic [31:0] d0, input logic [31:0] pat, input int plen);
        int i = 0;
        int c = 0;
        while (i < n && c < 200) begin
            word_valid_in = (plen == 0) ? 1'b1 : pat[c % plen];
            word_data_in  = d0 + 32'(i);
            if (word_valid_in) i++;
            c++;
            @(negedge clock);
        end
        word_valid_in = 0;
    endtask

    // End level schedule by RUN cycle c (1-based): high for c<lo_at,
    // low for lo_at<=c<hi_at, high from hi_at on.
    task automatic do_run(input int lo_at, input int hi_at, input int exp_rise);
        bit seen = 0;
        end_signal_in = 1;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clock);
            if (core_run_out) seen = 1;
        end
        chk("release_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("release_delay", 32'(cyc - last_strobe_cyc), 32'(exp_rise));
            for (int c = 1; c <= hi_at; c++) begin
                if (c > 1) @(negedge clock);
                end_signal_in = (c < lo_at) ? 1'b1 : ((c < hi_at) ? 1'b0 : 1'b1);
            end
            @(negedge clock);
            chk("done_pulse", 32'(done_out), 32'd1);
            chk("run_len", run_cycles_out, 32'(hi_at));
            chk("run_dropped", 32'(core_run_out), 32'd0);
            chk("busy_after", 32'(busy_out), 32'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d0;
        #1 reset_n = 0;
        repeat (3) @(negedge clock);
        reset_n = 1;
        @(negedge clock);
        chk("rst_state", 32'(dbg_state_out), 32'd0);
        chk("rst_pc", initial_pc_out, 32'd0);

        // Bad requests.
        st_addr_q.delete();
        start(32'h10, 16'd0);
        chk("bad0_err", 32'(error_out), 32'd1);
        chk("bad0_state", 32'(dbg_state_out), 32'd0);
        start(32'h10, 16'(MAX_WORDS + 1));
        chk("badmax_err", 32'(error_out), 32'd1);
        chk("badmax_busy", 32'(busy_out), 32'd0);
        repeat (2) @(negedge clock);
        chk("bad_nostrobe", 32'(st_addr_q.size()), 32'd0);

        // A valid single-word start clears the error.
        start(32'h40, 16'd1);
        chk("err_cleared", 32'(error_out), 32'd0);
        send(1, 32'h55, 0, 0);
        do_run(2, 5, 1 + SETTLE_CYCLES);

        // Load 12 words with continuous valid.
        st_addr_q.delete();
        d0 = done_cnt;
        start(32'd14, 16'd12);
        send(12, 32'hA0, 0, 0);
        do_run(4, 40, 1 + SETTLE_CYCLES);
        repeat (3) @(negedge clock);
        chk("l12_count", 32'(st_addr_q.size()), 32'd12);
        if (st_addr_q.size() == 12) begin
            chk("l12_first", st_addr_q[0], 32'd14);
            chk("l12_last", st_addr_q[11], 32'd25);
        end
        chk("l12_span", 32'(last_strobe_cyc - first_strobe_cyc), 32'd11);
        chk("l12_pc", initial_pc_out, 32'd14);
        chk("l12_one_done", 32'(done_cnt - d0), 32'd1);
        chk("l12_frozen", run_cycles_out, 32'd40);

        // Backpressure: valid 1,0,0,1,1,0,1.
        st_addr_q.delete();
        start(32'h100, 16'd4);
        send(4, 32'hB0, 32'b1011001, 7);
        do_run(2, 6, 1 + SETTLE_CYCLES);
        chk("bp_count", 32'(st_addr_q.size()), 32'd4);
        for (int k = 0; k < st_addr_q.size() && k < 4; k++)
            chk("bp_addr", st_addr_q[k], 32'h100 + 32'(k));

        // Address wrap, with a start request during LOAD that must be ignored.
        st_addr_q.delete();
        start(32'hFFFF_FFFE, 16'd3);
        word_valid_in = 1; word_data_in = 32'hC0;
        @(negedge clock);
        word_data_in = 32'hC1; load_start_in = 1; base_pc_in = 32'h1234; word_count_in = 16'd7;
        @(negedge clock);
        word_data_in = 32'hC2; load_start_in = 0;
        @(negedge clock);
        word_valid_in = 0;
        do_run(2, 5, 1 + SETTLE_CYCLES);
        chk("wrap_count", 32'(st_addr_q.size()), 32'd3);
        if (st_addr_q.size() == 3) begin
            chk("wrap_a0", st_addr_q[0], 32'hFFFF_FFFE);
            chk("wrap_a1", st_addr_q[1], 32'hFFFF_FFFF);
            chk("wrap_a2", st_addr_q[2], 32'h0000_0000);
        end
        chk("wrap_pc", initial_pc_out, 32'hFFFF_FFFE);
        chk("wrap_noerr", 32'(error_out), 32'd0);

        // Reset in the middle of LOAD after 2 of 5 words.
        start(32'h200, 16'd5);
        send(2, 32'hD0, 0, 0);
        @(posedge clock);
        #2 reset_n = 0;
        #1;
        chk("mid_rst_wr_en", 32'(ins_wr_en_out), 32'd0);
        chk("mid_rst_ready", 32'(word_ready_out), 32'd0);
        chk("mid_rst_busy", 32'(busy_out), 32'd0);
        chk("mid_rst_addr", ins_wr_addr_out, 32'd0);
        chk("mid_rst_pc", initial_pc_out, 32'd0);
        chk("mid_rst_state", 32'(dbg_state_out), 32'd0);
        @(negedge clock);
        reset_n = 1;
        st_addr_q.delete();
        start(32'h300, 16'd5);
        send(5, 32'hE0, 0, 0);
        do_run(2, 6, 1 + SETTLE_CYCLES);
        chk("reload_count", 32'(st_addr_q.size()), 32'd5);
        if (st_addr_q.size() > 0) chk("reload_first", st_addr_q[0], 32'h300);

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ins_boot_loader.md
Name: ins_boot_loader

Overview:
- Upstream of SINGLE_CORE: streams a program image into instruction memory, then releases the core and times its run.
- Word source is a valid/ready stream, e.g. a host or debug link.
- Writes go out over a one-word-per-cycle port to the instruction memory write path, the same function as write_ins_data.
- Drives initial_pc_in and a run enable into the core, watches end_signal_out for completion, and reports the run length in clock cycles.

Parameters:
MAX_WORDS, 256, largest accepted program length in words (1..65535)
SETTLE_CYCLES, 2, idle cycles between the last memory write and core release (≥1)
CNT_W, 32, width of run cycle counter

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
load_start_in  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE
base_pc_in  in  32  first instruction address; sampled with load_start_in
word_count_in  in  16  number of words to load; sampled with load_start_in
word_valid_in  in  1  stream word available
word_data_in  in  32  stream instruction word
word_ready_out  out  1  loader accepts word this cycle
ins_wr_en_out  out  1  instruction memory write strobe
ins_wr_addr_out  out  32  instruction memory word address
ins_wr_data_out  out  32  instruction word to write
initial_pc_out  out  32  to core initial_pc_in; holds latched base_pc
core_run_out  out  1  core release/enable
end_signal_in  in  1  from core end_signal_out
busy_out  out  1  high in LOAD, SETTLE, RUN
done_out  out  1  one-cycle pulse on run completion
error_out  out  1  sticky bad-request flag
run_cycles_out  out  CNT_W  cycles spent in RUN for last or current run

Behaviour:
- Reset, asynchronous: state=IDLE.
  - All outputs 0; initial_pc_out=0; run_cycles_out=0.
  - Index, settle and run counters cleared; end_seen_low cleared.
  - Mid-operation reset aborts immediately. No further writes; core_run_out drops asynchronously.
- States: IDLE, LOAD, SETTLE, RUN, DONE.
- IDLE/DONE + load_start_in:
  - If word_count_in==0 or >MAX_WORDS: error_out<=1 and stay in the current state.
  - Otherwise: latch base_pc_in into initial_pc_out and word_count_in; index<=0; error_out<=0; run_cycles_out<=0; go to LOAD.
- LOAD:
  - word_ready_out=1, combinational from state.
  - A transfer happens on a cycle with word_valid_in&&word_ready_out.
  - On transfer, registered for the next cycle: ins_wr_en_out=1, ins_wr_addr_out=base+index (32-bit, wraps modulo 2^32), ins_wr_data_out=word_data_in; index++.
  - ins_wr_en_out is 0 on non-transfer cycles. Addr/data hold their last values.
  - Write latency is 1 cycle; throughput is 1 word/cycle.
  - On the transfer of word count-1, go to SETTLE. word_ready_out is 0 from that next cycle onward, so extra stream words are never consumed.
- SETTLE:
  - The final write strobe occurs in the first SETTLE cycle.
  - Count SETTLE_CYCLES cycles after that strobe, then go to RUN.
- RUN:
  - core_run_out=1, registered, asserted in the first RUN cycle.
  - run_cycles_out increments each RUN cycle and saturates at all-ones.
  - end_seen_low sets when end_signal_in==0 is sampled.
  - Completion is a sample of end_signal_in==1 with end_seen_low already set, i.e. a genuine rising edge after the core started. On completion: go to DONE, pulse done_out one cycle, drop core_run_out.
  - A high end_signal_in before it has been seen low is ignored.
- DONE:
  - Outputs hold; run_cycles_out is frozen; busy_out=0.
  - A new load_start_in begins a fresh load with the same rules as IDLE.
- load_start_in in LOAD/SETTLE/RUN: ignored; no error raised.
- load_start_in and word_valid_in in the same IDLE cycle: no transfer. The first transfer is possible the cycle after entering LOAD.
- busy_out = state∈{LOAD,SETTLE,RUN}.

Test Plan:
- Load 12 words:
  - Stimulus: base_pc=14, count=12, continuous valid, words 0xA0+i.
  - Writes to addrs 14..25 with data 0xA0..0xAB on 12 consecutive cycles.
  - core_run_out rises 1+SETTLE_CYCLES cycles after the last strobe; initial_pc_out=14.
- Backpressure: count=4 with word_valid_in toggled 1,0,0,1,1,0,1.
  - Exactly 4 strobes, addresses contiguous, no duplicates.
  - Strobes occur only one cycle after each valid-high cycle.
- Run timing:
  - end_signal_in high at release, low 3 cycles later, high again after 40 RUN cycles.
  - Single done_out pulse; run_cycles_out=40; core_run_out=0.
  - The initial high level must not complete the run.
- Bad requests:
  - count=0 → error_out=1, no strobes, state stays IDLE.
  - count=MAX_WORDS+1 → same result.
  - A following valid start (count=1) clears error_out.
- Wrap and ignore:
  - base=0xFFFFFFFE, count=3 → addrs FFFFFFFE, FFFFFFFF, 00000000.
  - load_start_in pulsed during LOAD is ignored.
- Reset mid-LOAD after 2 of 5 words:
  - All outputs 0 immediately.
  - A new start reloads from index 0.
